button_debounce: RTL



---
 rtl/button_debounce_pkg.sv | 21 ++
 rtl/button_debounce_ch.sv | 174 +++++++++++++++++
 rtl/button_debounce.sv | 50 +++++
 3 files changed

// File: rtl/button_debounce_pkg.sv
// Shared types and helpers for the push-button debouncer.
// Optional feature macro: BUTTON_DEBOUNCE_AUTOREPEAT_EN (auto-repeat press pulses).
package button_debounce_pkg;

    // Per-channel debounce FSM state
    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } db_state_e;

    // Number of flops in the input synchroniser
    localparam int SYNC_DEPTH = 2;

    // Bits needed to hold values 0..n (at least one bit)
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: polarity fix, 2-flop synchroniser, debounce FSM with
// stability counter, registered level and press/release pulses.
// Optional feature macro: BUTTON_DEBOUNCE_AUTOREPEAT_EN adds a hold counter
// that re-issues press pulses while the button stays held.
module button_debounce_ch
    import button_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter bit ACTIVE_LOW      = 1'b1
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
    ,
    parameter int HOLD_CYCLES     = 8388608,
    parameter int REPEAT_CYCLES   = 2097152
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic button_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic                  raw_pressed;
    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  s;

    db_state_e             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  level_q, level_d;
    logic                  press_q, press_d;
    logic                  release_q, release_d;
    logic                  press_nxt;

    // Normalise so that 1 always means "pressed" before synchronising
    assign raw_pressed = ACTIVE_LOW ? ~button_i : button_i;
    assign s           = sync_q[SYNC_DEPTH-1];

    // Synchroniser shift chain for the asynchronous pin
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], raw_pressed};
        end
    end

    // Next-state logic: a change is accepted only after DEBOUNCE_CYCLES
    // consecutive samples at the new value; any opposite sample restarts
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (s) begin
                    state_d = ST_PRESS_CHK;
                    cnt_d   = CW'(1);
                end
            end
            ST_PRESS_CHK: begin
                if (!s) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_PRESSED: begin
                if (!s) begin
                    state_d = ST_RELEASE_CHK;
                    cnt_d   = CW'(1);
                end
            end
            ST_RELEASE_CHK: begin
                if (s) begin
                    // Bounce back to held: no pulse, level never dropped
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_RELEASED;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
    localparam int            HMAX      = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int            HW        = cnt_width(HMAX);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          rep_q, rep_d;   // first repeat already issued
    logic          rep_fire;

    // Hold counter: cleared on acceptance, advances only while staying in
    // PRESSED, so it freezes across a RELEASE_CHK excursion
    always_comb begin
        hold_d   = hold_q;
        rep_d    = rep_q;
        rep_fire = 1'b0;
        if (state_q == ST_PRESS_CHK && s && cnt_q == CNT_LAST) begin
            hold_d = '0;
            rep_d  = 1'b0;
        end else if (state_q == ST_PRESSED && s) begin
            if (hold_q == (rep_q ? REP_LAST : HOLD_LAST)) begin
                hold_d   = '0;
                rep_d    = 1'b1;
                rep_fire = 1'b1;
            end else begin
                hold_d = hold_q + HW'(1);
            end
        end
    end

    // Hold counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
            rep_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end

    assign press_nxt = press_d | rep_fire;
`else
    assign press_nxt = press_d;
`endif

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_nxt;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/button_debounce.sv
// Debounces N raw push-buttons into clean levels plus one-cycle
// press/release pulses; one independent channel per button.
// Optional feature macro: BUTTON_DEBOUNCE_AUTOREPEAT_EN (auto-repeat).
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int HOLD_CYCLES     = 8388608,
    parameter int REPEAT_CYCLES   = 2097152
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] button_i,
    output logic [N-1:0] level_o,
    output logic [N-1:0] press_o,
    output logic [N-1:0] release_o
);

    localparam bit CFG_OK = (DEBOUNCE_CYCLES >= 2) && (HOLD_CYCLES >= 1) && (REPEAT_CYCLES >= 1);

    // Reject unusable parameter sets at elaboration
    generate
        if (!CFG_OK) begin : g_cfg_err
            $error("button_debounce: DEBOUNCE_CYCLES must be >= 2, HOLD/REPEAT_CYCLES >= 1");
        end
    endgenerate

    // One debouncer per button; channels share nothing but clock and reset
    for (genvar i = 0; i < N; i++) begin : g_ch
        button_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
`ifdef BUTTON_DEBOUNCE_AUTOREPEAT_EN
            ,
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
`endif
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .button_i  (button_i[i]),
            .level_o   (level_o[i]),
            .press_o   (press_o[i]),
            .release_o (release_o[i])
        );
    end

endmodule
